// File: rtl/adex_core_scheduler.sv
// -----------------------------------------------------------------------------
// adex_core_scheduler
//
// Time-multiplexes one AdEx neuron update core across N_NEURONS contexts.
// A free-running timestep generator fires once every TICK_DIV cycles; each
// tick starts a sweep that walks context ids 0..N_NEURONS-1, and for every
// id enabled in neuron_mask sends its stored (V, w) to the core, waits for
// the result, writes it back and queues a spike event when the core fired.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   enable                run the timestep generator
//   neuron_mask           bit i = 1 -> context i is updated in a sweep
//   clr_status            pulse, clears the sticky flags
//   core_start/core_id    one-cycle launch of a core update for core_id
//   core_V_in/core_w_in   stored Q8.8 state of the context being launched
//   core_done/_V_out/_w_out/_spike   core result, valid while core_done = 1
//   ev_valid/ev_id/ev_ready          spike-event FIFO head and pop
//   rd_sel/rd_V/rd_w      combinational readback of one context
//   busy                  sweep in progress
//   overrun               tick arrived while a sweep was still running
//   timeout_err           core did not answer within DONE_TIMEOUT cycles
//   ev_drop               spike event lost because the FIFO was full
// -----------------------------------------------------------------------------
module adex_core_scheduler #(
    parameter int N_NEURONS    = 4,
    parameter int TICK_DIV     = 1000,
    parameter int DONE_TIMEOUT = 64,
    parameter int EV_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_NEURONS-1:0]      neuron_mask,
    input  logic                      clr_status,
    output logic                      core_start,
    output logic [1:0]                core_id,
    output logic signed [15:0]        core_V_in,
    output logic signed [15:0]        core_w_in,
    input  logic                      core_done,
    input  logic signed [15:0]        core_V_out,
    input  logic signed [15:0]        core_w_out,
    input  logic                      core_spike,
    output logic                      ev_valid,
    output logic [1:0]                ev_id,
    input  logic                      ev_ready,
    input  logic [1:0]                rd_sel,
    output logic signed [15:0]        rd_V,
    output logic signed [15:0]        rd_w,
    output logic                      busy,
    output logic                      overrun,
    output logic                      timeout_err,
    output logic                      ev_drop
);

    localparam int DATA_W = 16;
    // id must be able to hold N_NEURONS itself: that value ends the sweep.
    localparam int ID_W   = ($clog2(N_NEURONS + 1) > 2) ? $clog2(N_NEURONS + 1) : 2;
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W   = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
    localparam int PTR_W  = (EV_DEPTH > 1) ? $clog2(EV_DEPTH) : 1;
    localparam int OCC_W  = $clog2(EV_DEPTH + 1);

    // Resting potential -65 mV in Q8.8.
    localparam logic signed [DATA_W-1:0] V_REST = 16'shBF00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_WAIT_DONE,
        S_WRITEBACK
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(EV_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_t                   state, state_nxt;
    logic [ID_W-1:0]          id, id_nxt;
    logic [CNT_W-1:0]         tick_cnt;
    logic                     tick;
    logic [TO_W-1:0]          to_cnt;
    logic                     to_load, to_expire, res_capture, ctx_we, ev_push;
    logic                     mask_bit;

    logic signed [DATA_W-1:0] ctx_v [N_NEURONS];
    logic signed [DATA_W-1:0] ctx_w [N_NEURONS];

    // Core result held for the writeback cycle.
    logic signed [DATA_W-1:0] res_v_p1, res_w_p1;
    logic                     res_spk_p1;

    logic [1:0]               ev_mem [EV_DEPTH];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [OCC_W-1:0]         ev_cnt;
    logic                     ev_full, ev_pop, ev_wr;

    // Timestep generator: tick is the cycle the counter wraps back to 0.
    assign tick = enable && (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (!enable || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Mask is looked at only here, so changes during an update are seen by
    // the next SELECT and never by the context already in flight.
    always_comb begin
        mask_bit = 1'b0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (id == ID_W'(i)) mask_bit = neuron_mask[i];
        end
    end

    always_comb begin
        state_nxt   = state;
        id_nxt      = id;
        to_load     = 1'b0;
        to_expire   = 1'b0;
        res_capture = 1'b0;
        ctx_we      = 1'b0;
        ev_push     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    id_nxt    = '0;
                    state_nxt = S_SELECT;
                end
            end
            S_SELECT: begin
                if (id >= ID_W'(N_NEURONS)) begin
                    state_nxt = S_IDLE;
                end else if (!mask_bit) begin
                    id_nxt = id + 1'b1;
                end else begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_load   = 1'b1;
                state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    res_capture = 1'b1;
                    state_nxt   = S_WRITEBACK;
                end else if (to_cnt == TO_W'(DONE_TIMEOUT - 1)) begin
                    // Give up on this context, keep its old state, move on.
                    to_expire = 1'b1;
                    id_nxt    = id + 1'b1;
                    state_nxt = S_SELECT;
                end
            end
            S_WRITEBACK: begin
                ctx_we    = 1'b1;
                ev_push   = res_spk_p1;
                id_nxt    = id + 1'b1;
                state_nxt = S_SELECT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            id         <= '0;
            to_cnt     <= '0;
            res_spk_p1 <= 1'b0;
        end else begin
            state <= state_nxt;
            id    <= id_nxt;
            if (to_load) begin
                to_cnt <= '0;
            end else if (state == S_WAIT_DONE) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (res_capture) res_spk_p1 <= core_spike;
        end
    end

    // ---- stage p1: core result captured on core_done ----
    always_ff @(posedge clk) begin
        if (res_capture) begin
            res_v_p1 <= core_V_out;
            res_w_p1 <= core_w_out;
        end
    end

    // Context store: written verbatim from the captured result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                ctx_v[i] <= V_REST;
                ctx_w[i] <= '0;
            end
        end else if (ctx_we) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                if (id == ID_W'(i)) begin
                    ctx_v[i] <= res_v_p1;
                    ctx_w[i] <= res_w_p1;
                end
            end
        end
    end

    always_comb begin
        core_V_in = V_REST;
        core_w_in = '0;
        rd_V      = V_REST;
        rd_w      = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (id == ID_W'(i)) begin
                core_V_in = ctx_v[i];
                core_w_in = ctx_w[i];
            end
            if (rd_sel == 2'(i)) begin
                rd_V = ctx_v[i];
                rd_w = ctx_w[i];
            end
        end
    end

    assign core_start = (state == S_ISSUE);
    assign core_id    = id[1:0];
    assign busy       = (state != S_IDLE);

    // Spike-event FIFO. When full, a push still succeeds if the head is
    // being popped in the same cycle (the freed slot is the one written).
    assign ev_full  = (ev_cnt == OCC_W'(EV_DEPTH));
    assign ev_valid = (ev_cnt != '0);
    assign ev_pop   = ev_valid && ev_ready;
    assign ev_wr    = ev_push && (!ev_full || ev_pop);
    assign ev_id    = ev_valid ? ev_mem[rd_ptr] : 2'b00;

    always_ff @(posedge clk) begin
        if (ev_wr) ev_mem[wr_ptr] <= id[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ev_cnt <= '0;
        end else begin
            if (ev_wr)  wr_ptr <= ptr_inc(wr_ptr);
            if (ev_pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({ev_wr, ev_pop})
                2'b10:   ev_cnt <= ev_cnt + 1'b1;
                2'b01:   ev_cnt <= ev_cnt - 1'b1;
                default: ev_cnt <= ev_cnt;
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clr_status wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            ev_drop     <= 1'b0;
        end else begin
            if (tick && (state != S_IDLE))  overrun <= 1'b1;
            else if (clr_status)            overrun <= 1'b0;
            if (to_expire)                  timeout_err <= 1'b1;
            else if (clr_status)            timeout_err <= 1'b0;
            if (ev_push && ev_full && !ev_pop) ev_drop <= 1'b1;
            else if (clr_status)               ev_drop <= 1'b0;
        end
    end

endmodule

// File: doc/adex_core_scheduler.md
ADEX_CORE_SCHEDULER -- requirements
Module: adex_core_scheduler

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4, number of neuron contexts sharing one AdEx update core (2-bit id).
REQ-002 SHALL have parameter TICK_DIV, default 1000, clk cycles per simulation timestep.
REQ-003 SHALL have parameter DONE_TIMEOUT, default 64, max cycles from core_start to core_done.
REQ-004 SHALL have parameter EV_DEPTH, default 4, spike-event FIFO depth.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 enable  in  1  run timestep generator.
REQ-008 neuron_mask  in  N_NEURONS  bit i=1 means context i is updated.
REQ-009 clr_status  in  1  one-cycle pulse, clears sticky flags.
REQ-010 core_start  out  1  one-cycle pulse, launches one core update.
REQ-011 core_id / core_V_in / core_w_in  out  2 / 16 / 16  context id and signed Q8.8 state sent to core.
REQ-012 core_done / core_V_out / core_w_out / core_spike  in  1 / 16 / 16 / 1  core result, valid when core_done=1.
REQ-013 ev_valid / ev_id  out  1 / 2  spike-event FIFO head; ev_ready  in  1  consumer pop.
REQ-014 rd_sel  in  2; rd_V / rd_w  out  16 / 16  combinational readback of context rd_sel.
REQ-015 busy  out  1  sweep in progress; overrun / timeout_err / ev_drop  out  1 each, sticky flags.

Function
REQ-016 Tick counter SHALL count 0..TICK_DIV-1 while enable=1, emit internal tick on wrap to 0, hold at 0 while enable=0.
REQ-017 FSM states SHALL be IDLE, SELECT, ISSUE, WAIT_DONE, WRITEBACK.
REQ-018 IDLE: on tick, id:=0, go SELECT, busy=1.
REQ-019 SELECT: if id>=N_NEURONS -> IDLE, busy=0; elif neuron_mask[id]=0 -> id+1, stay SELECT; else -> ISSUE.
REQ-020 ISSUE: assert core_start for exactly one cycle with core_id=id, core_V_in/core_w_in = stored context; load timeout counter 0; -> WAIT_DONE.
REQ-021 WAIT_DONE: core_done=1 -> WRITEBACK, capturing core_V_out, core_w_out, core_spike that cycle; core_done ignored in all other states.
REQ-022 WAIT_DONE: counter reaching DONE_TIMEOUT without core_done SHALL set timeout_err, leave context unchanged, id+1, -> SELECT.
REQ-023 WRITEBACK: store captured V, w into context id; if spike captured, push id to event FIFO; id+1; -> SELECT; one cycle.
REQ-024 Tick arriving while FSM not IDLE SHALL be dropped and set overrun; sweep continues unaffected.
REQ-025 enable falling mid-sweep SHALL not abort the sweep; it completes and returns to IDLE.
REQ-026 neuron_mask SHALL be sampled in SELECT only; changes mid-issue affect only later selections.
REQ-027 FIFO: ev_valid = not empty; pop on ev_valid&&ev_ready; order preserved.
REQ-028 Push when full and no pop SHALL drop the event and set ev_drop; push and pop in same cycle when full SHALL both succeed.
REQ-029 clr_status SHALL clear overrun, timeout_err, ev_drop; a same-cycle set event SHALL win over clear.
REQ-030 Context values SHALL be stored verbatim (no saturation or arithmetic in this block).
REQ-031 Minimum sweep latency SHALL be 1 + Σ(active: 1 ISSUE + k WAIT_DONE + 1 WRITEBACK) + (N_NEURONS+1) SELECT cycles; core must not be restarted before its done.

Reset
REQ-032 On reset: FSM IDLE, id=0, tick counter 0, FIFO empty, all sticky flags 0.
REQ-033 On reset: outputs core_start=0, core_id=0, core_V_in=-16640 (0xBF00, -65 mV), core_w_in=0, ev_valid=0, ev_id=0, busy=0.
REQ-034 On reset: every context V=0xBF00, w=0x0000.
REQ-035 Reset asserted mid-sweep SHALL abandon the sweep immediately; a later core_done SHALL be ignored.

Verification
REQ-036 TICK_DIV=8, mask=4'b1111, core model done after 3 cycles returning V=V_in+256 -> one sweep every 8 cycles... set TICK_DIV=40: four core_start pulses ids 0,1,2,3, rd_V(i)=0xC000 after sweep.
REQ-037 mask=4'b0101 -> only ids 0 and 2 issued; contexts 1,3 remain 0xBF00.
REQ-038 Core never asserts done for id 1 -> timeout_err=1 after 64 cycles, context 1 unchanged, ids 2,3 still issued.
REQ-039 Core spikes on every update, ev_ready=0, EV_DEPTH=4 -> ev_valid=1, after 4 pushes 5th drops and ev_drop=1; ev_ready=1 then yields ids 0,1,2,3 in order.
REQ-040 TICK_DIV=8 with core latency 10 -> overrun=1 on second tick; clr_status clears it; reset mid-WAIT_DONE -> busy=0, core_start=0, contexts 0xBF00/0.
